regfile_port_arbiter: RTL

- Controller for the 32 x 32-bit register file built from 32 single-register cells. Each cell has a write strobe and two tri-state read enables.
- Arbitrates two write requesters onto the single write port:
  - requester 0: pipeline WB stage;
  - requester 1: multi-cycle/load-return unit.
- Uses round-robin arbitration with a valid/ready handshake and a one-stage commit register.
- Drives the one-hot write selects and the one-hot A/B read-bus enables, and flags read-after-write hazards against the in-flight write.

---
 rtl/regfile_port_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin write-port arbiter, commit stage, read decode and RAW hazards (REGARB_BYPASS_EN adds a bypass path)
module regfile_port_arbiter #(
  parameter int NREGS = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  input  logic             rd_a_en,
  input  logic [4:0]       rd_a_addr,
  input  logic             rd_b_en,
  input  logic [4:0]       rd_b_addr,
  output logic [NREGS-1:0] wr_dselect,
  output logic [DW-1:0]    wr_data,
  output logic             wr_strobe,
  output logic [NREGS-1:0] asel,
  output logic [NREGS-1:0] bsel,
`ifdef REGARB_BYPASS_EN
  output logic             byp_a_en,
  output logic             byp_b_en,
  output logic [DW-1:0]    byp_data,
`endif
  output logic             rd_a_hazard,
  output logic             rd_b_hazard
);
  localparam logic [NREGS-1:0] ONE = NREGS'(1);
  logic          last_grant, open, gnt0, gnt1, any_gnt, live;
  logic [4:0]    waddr, gaddr;
  logic [DW-1:0] gdata;
  logic          haz_a, haz_b;
  always_comb begin
    open = !freeze && !reset;
    gnt0 = open && req0_valid && (!req1_valid || last_grant);
    gnt1 = open && req1_valid && (!req0_valid || !last_grant);
    any_gnt = gnt0 || gnt1;
    gaddr = gnt1 ? req1_addr : req0_addr;
    gdata = gnt1 ? req1_data : req0_data;
    live = any_gnt && gaddr != 5'd0;
    asel = rd_a_en ? ONE << rd_a_addr : '0;
    bsel = rd_b_en ? ONE << rd_b_addr : '0;
    haz_a = rd_a_en && wr_strobe && rd_a_addr == waddr;
    haz_b = rd_b_en && wr_strobe && rd_b_addr == waddr;
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
`ifdef REGARB_BYPASS_EN
  assign byp_a_en = haz_a;
  assign byp_b_en = haz_b;
  assign byp_data = wr_data;
  assign rd_a_hazard = 1'b0;
  assign rd_b_hazard = 1'b0;
`else
  assign rd_a_hazard = haz_a;
  assign rd_b_hazard = haz_b;
`endif
  // writes to register 0 are accepted but never strobe a cell
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_strobe  <= 1'b0;
      wr_dselect <= '0;
      wr_data    <= '0;
      waddr      <= '0;
      last_grant <= 1'b1;
    end else begin
      wr_strobe  <= live;
      wr_dselect <= live ? ONE << gaddr : '0;
      if (any_gnt) begin
        waddr      <= gaddr;
        wr_data    <= gdata;
        last_grant <= gnt1;
      end
    end
  end
endmodule
